// File: rtl/mod_seq_pkg.sv
// -----------------------------------------------------------------------------
// mod_seq_pkg
// Shared types and elaboration-time helpers for the modulo-N sequencer.
//   dir_t              : count direction (DIR_UP / DIR_DOWN)
//   mod_seq_params_ok  : returns 1 when the WIDTH/MODULUS/STEP/WRAP_CNT_W
//                        combination is legal
// Optional feature macro: MOD_SEQ_DOWN_EN (down-count mode, see top level).
// -----------------------------------------------------------------------------
package mod_seq_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Legal ranges: 1 <= WIDTH (kept below 31 so 2^WIDTH fits in an int),
    // 2 <= MODULUS <= 2^WIDTH, 1 <= STEP < MODULUS, WRAP_CNT_W >= 1.
    function automatic bit mod_seq_params_ok(input int width,
                                             input int modulus,
                                             input int step,
                                             input int wrap_cnt_w);
        return (width >= 1) && (width <= 30) &&
               (modulus >= 2) && (modulus <= (1 << width)) &&
               (step >= 1) && (step < modulus) &&
               (wrap_cnt_w >= 1);
    endfunction

endpackage

// File: rtl/mod_seq_step.sv
// -----------------------------------------------------------------------------
// mod_seq_step
// Purely combinational single-step function of the modulo-N sequencer.
// Given the current state it returns the state after one advance by STEP and
// whether that advance wrapped past MODULUS-1 (or below 0 when counting down).
// Out-of-range states map to 0 without a wrap.
// Ports:
//   cnt      in  WIDTH  current state
//   dir      in  dir_t  count direction (only with MOD_SEQ_DOWN_EN)
//   nxt_val  out WIDTH  state after one step
//   wrap     out 1      the step wrapped
// Optional feature macro: MOD_SEQ_DOWN_EN (adds dir input and down step).
// -----------------------------------------------------------------------------
module mod_seq_step
    import mod_seq_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 3,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] cnt,
`ifdef MOD_SEQ_DOWN_EN
    input  dir_t             dir,
`endif
    output logic [WIDTH-1:0] nxt_val,
    output logic             wrap
);

    // All arithmetic is done one bit wider so cnt+STEP and MODULUS itself
    // (which may equal 2^WIDTH) are representable.
    localparam logic [WIDTH:0] L_MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] L_STEP = (WIDTH+1)'(STEP);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_up;

    assign w_ext = {1'b0, cnt};
    assign w_up  = w_ext + L_STEP;

    always_comb begin
        nxt_val = '0;
        wrap    = 1'b0;
        if (w_ext >= L_MOD) begin
            // Illegal state: recover to zero, not counted as a wrap.
            nxt_val = '0;
            wrap    = 1'b0;
        end
`ifdef MOD_SEQ_DOWN_EN
        else if (dir == DIR_DOWN) begin
            if (w_ext < L_STEP) begin
                nxt_val = WIDTH'(w_ext + L_MOD - L_STEP);
                wrap    = 1'b1;
            end else begin
                nxt_val = WIDTH'(w_ext - L_STEP);
            end
        end
`endif
        else if (w_up >= L_MOD) begin
            nxt_val = WIDTH'(w_up - L_MOD);
            wrap    = 1'b1;
        end else begin
            nxt_val = WIDTH'(w_up);
        end
    end

endmodule

// File: rtl/mod_seq_counter.sv
// -----------------------------------------------------------------------------
// mod_seq_counter
// Parametrised modulo-N cyclic sequencer with load, enable, registered wrap
// flag and saturating wrap counter.
// Ports:
//   clk         in  1           clock, rising edge
//   reset_n     in  1           synchronous active-low reset
//   en          in  1           advance by STEP on this edge
//   load        in  1           load load_val (out-of-range loads give 0)
//   load_val    in  WIDTH       value for load
//   dir         in  1           0 = up, 1 = down (only with MOD_SEQ_DOWN_EN)
//   cnt         out WIDTH       current state
//   nxt         out WIDTH       value cnt takes on an en-only edge
//   wrap        out 1           cnt holds a post-wrap value
//   wrap_count  out WRAP_CNT_W  wraps since reset, saturating at all-ones
// Edge priority: reset, load, en, hold.
// Optional feature macro: MOD_SEQ_DOWN_EN (adds dir port and down-count mode).
// -----------------------------------------------------------------------------
module mod_seq_counter
    import mod_seq_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int MODULUS    = 3,
    parameter int STEP       = 1,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
`ifdef MOD_SEQ_DOWN_EN
    input  logic                  dir,
`endif
    output logic [WIDTH-1:0]      cnt,
    output logic [WIDTH-1:0]      nxt,
    output logic                  wrap,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    if (!mod_seq_params_ok(WIDTH, MODULUS, STEP, WRAP_CNT_W)) begin : g_param_err
        $error("mod_seq_counter: illegal WIDTH/MODULUS/STEP/WRAP_CNT_W");
    end

    localparam logic [WIDTH:0] L_MOD = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0]      r_cnt;
    logic                  r_wrap;
    logic [WRAP_CNT_W-1:0] r_wrap_count;

    logic [WIDTH-1:0]      w_step_nxt;
    logic                  w_step_wrap;
    logic [WIDTH-1:0]      w_load_val;

    // One step unit shared by the nxt output and the register update.
    mod_seq_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP    (STEP)
    ) u_step (
        .cnt     (r_cnt),
`ifdef MOD_SEQ_DOWN_EN
        .dir     (dir_t'(dir)),
`endif
        .nxt_val (w_step_nxt),
        .wrap    (w_step_wrap)
    );

    // Loads never create an illegal state.
    assign w_load_val = ({1'b0, load_val} >= L_MOD) ? '0 : load_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_wrap       <= 1'b0;
            r_wrap_count <= '0;
        end else if (load) begin
            r_cnt  <= w_load_val;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_step_nxt;
            r_wrap <= w_step_wrap;
            if (w_step_wrap && (r_wrap_count != {WRAP_CNT_W{1'b1}})) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end else begin
            // wrap marks only the cycle right after a wrapping step.
            r_wrap <= 1'b0;
        end
    end

    assign cnt        = r_cnt;
    assign nxt        = w_step_nxt;
    assign wrap       = r_wrap;
    assign wrap_count = r_wrap_count;

endmodule
